// File: rtl/matmul_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// matmul_ctrl_pkg
// Shared types and default constants for the matmul sequencer slice.
//   state_e   : sequencer FSM states
//   phase_e   : which buffer/datapath input a beat belongs to
//   tag_t     : per-beat control tag, registered once to line up with the
//               1-cycle-latency buffer read data
//   cnt_w()   : counter width helper (never returns 0)
// -----------------------------------------------------------------------------
package matmul_ctrl_pkg;

    localparam int DEF_K_LEN   = 4;
    localparam int DEF_N_SETS  = 8;
    localparam int DEF_GAP     = 2;
    localparam int DEF_L2_LEN  = 8;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_AW1     = 5;
    localparam int DEF_AW2     = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_P1    = 3'd1,
        ST_GAP1  = 3'd2,
        ST_GAP2  = 3'd3,
        ST_P2    = 3'd4,
        ST_DRAIN = 3'd5,
        ST_WAIT  = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    typedef enum logic {
        PH1 = 1'b0,
        PH2 = 1'b1
    } phase_e;

    typedef struct packed {
        logic   en;        // beat carries data into the datapath
        logic   last;      // last beat of a phase-1 set
        logic   is_final;  // last beat of the last phase-1 set
        logic   valid2;    // GAP2 / phase-2 qualifier
        phase_e phase;     // selects which buffer feeds the datapath
    } tag_t;

    // Width of a counter that must hold values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Phase-2 qualifier seen by the datapath.
    function automatic logic tag_valid2(input tag_t t);
        return t.is_final | t.valid2;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl_if
// Buffer-read and datapath bus between the sequencer and its neighbours.
// Signal suffixes are from the sequencer's point of view.
//   master : sequencer side (drives addresses and datapath controls)
//   slave  : buffers + multiplier side (drives read data and result)
// Signals:
//   buf1_addr_o / buf1_x_i / buf1_w_i : phase-1 buffer address, x, weight row
//   buf2_addr_o / buf2_w_i            : phase-2 buffer address, weight
//   mm_en_o, mm_valid_o, mm_valid2_o  : datapath enable / set end / phase-2
//   mm_din1_o, mm_din2_o, mm_din3_o   : gated datapath inputs
//   mm_vld_i, mm_result_i             : datapath result handshake
// -----------------------------------------------------------------------------
interface matmul_seq_ctrl_if
    import matmul_ctrl_pkg::*;
#(
    parameter int AW1 = DEF_AW1,
    parameter int AW2 = DEF_AW2
);

    logic [AW1-1:0] buf1_addr_o;
    logic [7:0]     buf1_x_i;
    logic [63:0]    buf1_w_i;
    logic [AW2-1:0] buf2_addr_o;
    logic [7:0]     buf2_w_i;
    logic           mm_en_o;
    logic           mm_valid_o;
    logic           mm_valid2_o;
    logic [7:0]     mm_din1_o;
    logic [63:0]    mm_din2_o;
    logic [7:0]     mm_din3_o;
    logic           mm_vld_i;
    logic [63:0]    mm_result_i;

    modport master (
        output buf1_addr_o, buf2_addr_o,
        output mm_en_o, mm_valid_o, mm_valid2_o,
        output mm_din1_o, mm_din2_o, mm_din3_o,
        input  buf1_x_i, buf1_w_i, buf2_w_i,
        input  mm_vld_i, mm_result_i
    );

    modport slave (
        input  buf1_addr_o, buf2_addr_o,
        input  mm_en_o, mm_valid_o, mm_valid2_o,
        input  mm_din1_o, mm_din2_o, mm_din3_o,
        output buf1_x_i, buf1_w_i, buf2_w_i,
        output mm_vld_i, mm_result_i
    );

endinterface

// File: rtl/matmul_beat_cnt.sv
// -----------------------------------------------------------------------------
// matmul_beat_cnt
// Nested set/beat counter. beat counts 0..BEATS-1; when it wraps, set
// advances and itself wraps after SETS-1. A clear has priority over inc.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clr_i          : return both counters to 0
//   inc_i          : advance by one beat
//   beat_o, set_o  : current beat / set index
//   beat_last_o    : beat_o == BEATS-1
//   set_last_o     : set_o  == SETS-1
// -----------------------------------------------------------------------------
module matmul_beat_cnt
    import matmul_ctrl_pkg::*;
#(
    parameter int BEATS = DEF_K_LEN,
    parameter int SETS  = DEF_N_SETS,
    localparam int BW   = cnt_w(BEATS),
    localparam int SW   = cnt_w(SETS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [BW-1:0] beat_o,
    output logic [SW-1:0] set_o,
    output logic          beat_last_o,
    output logic          set_last_o
);

    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] set_q, set_d;

    assign beat_o      = beat_q;
    assign set_o       = set_q;
    assign beat_last_o = (beat_q == BW'(BEATS - 1));
    assign set_last_o  = (set_q == SW'(SETS - 1));

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        beat_d = beat_q;
        set_d  = set_q;
        if (clr_i) begin
            beat_d = '0;
            set_d  = '0;
        end else if (inc_i) begin
            if (beat_last_o) begin
                beat_d = '0;
                set_d  = set_last_o ? '0 : set_q + SW'(1);
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
            set_q  <= '0;
        end else begin
            beat_q <= beat_d;
            set_q  <= set_d;
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
// Sequencer for the two-stage matrix multiplier datapath. On start it walks
// N_SETS sets of K_LEN phase-1 beats (GAP idle cycles between sets), then GAP
// cycles of phase-2 lead-in, L2_LEN phase-2 beats, one drain cycle, and waits
// up to TIMEOUT cycles for the datapath result.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : start pulse, only honoured in IDLE
//   busy_o       : high while not IDLE
//   done_o       : one-cycle pulse in DONE
//   err_o        : timeout flag, sticky until the next accepted start
//   res_o        : last captured datapath result
//   bus          : buffer read ports and datapath controls (master side)
// -----------------------------------------------------------------------------
module matmul_seq_ctrl
    import matmul_ctrl_pkg::*;
#(
    parameter int K_LEN   = DEF_K_LEN,
    parameter int N_SETS  = DEF_N_SETS,
    parameter int GAP     = DEF_GAP,
    parameter int L2_LEN  = DEF_L2_LEN,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int AW1     = DEF_AW1,
    parameter int AW2     = DEF_AW2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [63:0]        res_o,
    matmul_seq_ctrl_if.master  bus
);

    localparam int BW1 = cnt_w(K_LEN);
    localparam int SW1 = cnt_w(N_SETS);
    localparam int BW2 = cnt_w(L2_LEN);
    localparam int GW  = cnt_w(GAP);
    localparam int TW  = cnt_w(TIMEOUT + 1);

    state_e        state_q, state_d;
    tag_t          tag_q, tag_d;
    logic          err_q, err_d;
    logic [63:0]   res_q, res_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] to_q, to_d;

    logic           cnt_clr;
    logic           p1_inc, p2_inc;
    logic [BW1-1:0] p1_beat;
    logic [SW1-1:0] p1_set;
    logic           p1_beat_last, p1_set_last;
    logic [BW2-1:0] p2_beat;
    logic [0:0]     p2_set;
    logic           p2_beat_last, p2_set_last;
    logic           gap_last;

    matmul_beat_cnt #(.BEATS(K_LEN), .SETS(N_SETS)) u_p1_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (cnt_clr),
        .inc_i       (p1_inc),
        .beat_o      (p1_beat),
        .set_o       (p1_set),
        .beat_last_o (p1_beat_last),
        .set_last_o  (p1_set_last)
    );

    // Phase 2 is a single "set" of L2_LEN beats.
    matmul_beat_cnt #(.BEATS(L2_LEN), .SETS(1)) u_p2_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (cnt_clr),
        .inc_i       (p2_inc),
        .beat_o      (p2_beat),
        .set_o       (p2_set),
        .beat_last_o (p2_beat_last),
        .set_last_o  (p2_set_last)
    );

    assign gap_last = (gap_q == GW'(GAP - 1));

    always_comb begin
        state_d = state_q;
        tag_d   = '0;
        err_d   = err_q;
        res_d   = res_q;
        gap_d   = gap_q;
        to_d    = to_q;
        cnt_clr = 1'b0;
        p1_inc  = 1'b0;
        p2_inc  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_P1;
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end

            ST_P1: begin
                p1_inc         = 1'b1;
                tag_d.en       = 1'b1;
                tag_d.last     = p1_beat_last;
                tag_d.is_final = p1_beat_last & p1_set_last;
                tag_d.phase    = PH1;
                if (p1_beat_last) begin
                    if (p1_set_last) begin
                        state_d = (GAP == 0) ? ST_P2 : ST_GAP2;
                    end else if (GAP != 0) begin
                        state_d = ST_GAP1;
                    end
                end
            end

            ST_GAP1: begin
                if (gap_last) begin
                    gap_d   = '0;
                    state_d = ST_P1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            ST_GAP2: begin
                tag_d.valid2 = 1'b1;
                tag_d.phase  = PH2;
                if (gap_last) begin
                    gap_d   = '0;
                    state_d = ST_P2;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            ST_P2: begin
                p2_inc       = 1'b1;
                tag_d.en     = 1'b1;
                tag_d.valid2 = 1'b1;
                tag_d.phase  = PH2;
                if (p2_beat_last && p2_set_last) begin
                    state_d = ST_DRAIN;
                end
            end

            // Lets the last phase-2 tag leave the tag register before waiting.
            ST_DRAIN: begin
                to_d    = '0;
                state_d = ST_WAIT;
            end

            // A result arriving on the timeout cycle still counts as a capture.
            ST_WAIT: begin
                if (bus.mm_vld_i) begin
                    res_d   = bus.mm_result_i;
                    state_d = ST_DONE;
                end else if (to_q == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
            gap_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
            res_q   <= res_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
        end
    end

    // Addresses are issued combinationally from the counters so the read data
    // returns in the same cycle as the registered tag.
    assign bus.buf1_addr_o = (state_q == ST_P1)
                           ? AW1'(32'(p1_set) * 32'(K_LEN) + 32'(p1_beat)) : '0;
    assign bus.buf2_addr_o = (state_q == ST_P2)
                           ? AW2'(32'(p2_set) * 32'(L2_LEN) + 32'(p2_beat)) : '0;

    assign bus.mm_en_o     = tag_q.en;
    assign bus.mm_valid_o  = tag_q.last;
    assign bus.mm_valid2_o = tag_valid2(tag_q);

    assign bus.mm_din1_o = (tag_q.en && tag_q.phase == PH1) ? bus.buf1_x_i : '0;
    assign bus.mm_din2_o = (tag_q.en && tag_q.phase == PH1) ? bus.buf1_w_i : '0;
    assign bus.mm_din3_o = (tag_q.en && tag_q.phase == PH2) ? bus.buf2_w_i : '0;

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign err_o  = err_q;
    assign res_o  = res_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_seq_ctrl
// Directed bench for matmul_seq_ctrl. A default-parameter instance walks full
// runs (capture, timeout, capture-on-timeout, ignored start, mid-P2 reset) and
// a second instance with K_LEN=2, N_SETS=2, GAP=0, TIMEOUT=3 covers the
// gapless case. Expected beat positions come from a closed-form schedule:
// issue slot t (cycles after the start edge) maps to set/beat/gap/phase-2.
// -----------------------------------------------------------------------------
module tb_matmul_seq_ctrl;
    import matmul_ctrl_pkg::*;

    localparam int K  = 4, N  = 8, G  = 2, L = 8, TO  = 255;
    localparam int K2 = 2, N2 = 2, G2 = 0,        TO2 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic        busy, done, err, busy2, done2, err2;
    logic [63:0] res, res2;

    int n_checks = 0;
    int n_fail   = 0;

    matmul_seq_ctrl_if #(.AW1(5), .AW2(3)) bus ();
    matmul_seq_ctrl_if #(.AW1(5), .AW2(3)) bus2 ();

    matmul_seq_ctrl #(.K_LEN(K), .N_SETS(N), .GAP(G), .L2_LEN(L), .TIMEOUT(TO),
                      .AW1(5), .AW2(3)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .err_o(err), .res_o(res), .bus(bus)
    );

    matmul_seq_ctrl #(.K_LEN(K2), .N_SETS(N2), .GAP(G2), .L2_LEN(L), .TIMEOUT(TO2),
                      .AW1(5), .AW2(3)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
        .err_o(err2), .res_o(res2), .bus(bus2)
    );

    always #5 clk = ~clk;

    // Sync-read buffers, one cycle of latency.
    logic [7:0]  mem_x [0:31];
    logic [63:0] mem_w [0:31];
    logic [7:0]  mem2  [0:7] = '{8'd1, 8'd2, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd2};

    always @(posedge clk) begin
        bus.buf1_x_i  <= mem_x[bus.buf1_addr_o];
        bus.buf1_w_i  <= mem_w[bus.buf1_addr_o];
        bus.buf2_w_i  <= mem2[bus.buf2_addr_o];
        bus2.buf1_x_i <= mem_x[bus2.buf1_addr_o];
        bus2.buf1_w_i <= mem_w[bus2.buf1_addr_o];
        bus2.buf2_w_i <= mem2[bus2.buf2_addr_o];
    end

    typedef struct packed {
        bit p1;
        bit p2;
        bit gap2;
        bit last;
        bit fin;
        int a1;
        int a2;
    } slot_t;

    // What the sequencer issues in cycle t after the start edge (t=1 first).
    function automatic slot_t slot_at(input int t, input int k, input int n,
                                      input int g, input int l);
        slot_t s;
        int p1len, r, st, b;
        s = '0;
        p1len = n * k + (n - 1) * g;
        if (t >= 1 && t <= p1len) begin
            r  = t - 1;
            st = r / (k + g);
            b  = r % (k + g);
            if (b < k) begin
                s.p1   = 1'b1;
                s.a1   = st * k + b;
                s.last = (b == k - 1);
                s.fin  = (b == k - 1) && (st == n - 1);
            end
        end else if (t > p1len && t <= p1len + g) begin
            s.gap2 = 1'b1;
        end else if (t > p1len + g && t <= p1len + g + l) begin
            s.p2 = 1'b1;
            s.a2 = t - (p1len + g + 1);
        end
        return s;
    endfunction

    // One start of the default instance. vld_at=0 means no result is driven.
    task automatic run_main(input string name, input int last_t_in, input int vld_at,
                            input logic [63:0] result, input int glitch_at,
                            input int noise_at, input logic [63:0] prev_res);
        int          t_wait, done_at, last_t;
        slot_t       cur, prv;
        logic [4:0]  e_a1;
        logic [2:0]  e_a2, e_ctl, e_st;
        logic [7:0]  e_d1, e_d3;
        logic [63:0] e_d2, e_res;
        logic        e_err;
        t_wait  = N * K + (N - 1) * G + G + L + 2;
        done_at = (vld_at > 0) ? vld_at + 1 : t_wait + TO + 1;
        last_t  = (last_t_in > 0) ? last_t_in : done_at + 1;
        e_err   = (vld_at == 0);
        @(negedge clk);
        start = 1'b1;
        for (int t = 1; t <= last_t; t++) begin
            @(negedge clk);
            cur   = slot_at(t, K, N, G, L);
            prv   = slot_at(t - 1, K, N, G, L);
            e_a1  = cur.p1 ? 5'(cur.a1) : 5'd0;
            e_a2  = cur.p2 ? 3'(cur.a2) : 3'd0;
            e_ctl = {prv.p1 | prv.p2, prv.last, prv.fin | prv.gap2 | prv.p2};
            e_d1  = prv.p1 ? mem_x[prv.a1] : 8'd0;
            e_d2  = prv.p1 ? mem_w[prv.a1] : 64'd0;
            e_d3  = prv.p2 ? mem2[prv.a2] : 8'd0;
            e_st  = {t <= done_at, t == done_at, (t >= done_at) ? e_err : 1'b0};
            e_res = (t >= done_at && vld_at > 0) ? result : prev_res;

            n_checks += 8;
            if (bus.buf1_addr_o !== e_a1) begin
                n_fail++;
                $display("FAIL %s t=%0d buf1_addr got=%0d exp=%0d", name, t, bus.buf1_addr_o, e_a1);
            end
            if (bus.buf2_addr_o !== e_a2) begin
                n_fail++;
                $display("FAIL %s t=%0d buf2_addr got=%0d exp=%0d", name, t, bus.buf2_addr_o, e_a2);
            end
            if ({bus.mm_en_o, bus.mm_valid_o, bus.mm_valid2_o} !== e_ctl) begin
                n_fail++;
                $display("FAIL %s t=%0d en/valid/valid2 got=%b%b%b exp=%b", name, t,
                         bus.mm_en_o, bus.mm_valid_o, bus.mm_valid2_o, e_ctl);
            end
            if (bus.mm_din1_o !== e_d1) begin
                n_fail++;
                $display("FAIL %s t=%0d din1 got=%0d exp=%0d", name, t, bus.mm_din1_o, e_d1);
            end
            if (bus.mm_din2_o !== e_d2) begin
                n_fail++;
                $display("FAIL %s t=%0d din2 got=%h exp=%h", name, t, bus.mm_din2_o, e_d2);
            end
            if (bus.mm_din3_o !== e_d3) begin
                n_fail++;
                $display("FAIL %s t=%0d din3 got=%0d exp=%0d", name, t, bus.mm_din3_o, e_d3);
            end
            if ({busy, done, err} !== e_st) begin
                n_fail++;
                $display("FAIL %s t=%0d busy/done/err got=%b%b%b exp=%b", name, t, busy, done, err, e_st);
            end
            if (res !== e_res) begin
                n_fail++;
                $display("FAIL %s t=%0d res got=%h exp=%h", name, t, res, e_res);
            end

            start = (t == glitch_at);
            bus.mm_vld_i    = (t == vld_at) || (t == noise_at);
            bus.mm_result_i = (t == vld_at) ? result : 64'hDEAD_BEEF_0BAD_F00D;
        end
        start        = 1'b0;
        bus.mm_vld_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 4;
        if ({busy, done, err, bus.mm_en_o, bus.mm_valid_o, bus.mm_valid2_o} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset flags got=%b%b%b%b%b%b exp=000000", busy, done, err,
                     bus.mm_en_o, bus.mm_valid_o, bus.mm_valid2_o);
        end
        if ({bus.buf1_addr_o, bus.buf2_addr_o} !== 8'd0 || res !== 64'd0) begin
            n_fail++;
            $display("FAIL reset addr/res got=%0d/%0d/%h exp=0/0/0", bus.buf1_addr_o,
                     bus.buf2_addr_o, res);
        end
        if ({bus.mm_din1_o, bus.mm_din2_o, bus.mm_din3_o} !== 80'd0) begin
            n_fail++;
            $display("FAIL reset din got=%h/%h/%h exp=0", bus.mm_din1_o, bus.mm_din2_o, bus.mm_din3_o);
        end
        if ({busy2, done2, err2, bus2.mm_en_o} !== 4'd0 || res2 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset2 got=%b%b%b%b/%h exp=0000/0", busy2, done2, err2, bus2.mm_en_o, res2);
        end
        rst = 1'b0;
    endtask

    task automatic test_phase_capture;
        run_main("capture", 0, 68, 64'h0102030405060708, 0, 0, 64'd0);
    endtask

    task automatic test_timeout;
        run_main("timeout", 0, 0, 64'd0, 0, 0, 64'h0102030405060708);
    endtask

    task automatic test_timeout_race;
        // 58 is the first WAIT cycle, so 58+255 is the timeout cycle.
        run_main("race", 0, 58 + 255, 64'hCAFE_0000_1234_5678, 0, 0, 64'h0102030405060708);
    endtask

    task automatic test_start_ignored;
        run_main("start_ign", 0, 60, 64'h1111_2222_3333_4444, 10, 5, 64'hCAFE_0000_1234_5678);
    endtask

    task automatic test_reset_mid_p2;
        run_main("mid_p2", 52, 0, 64'd0, 0, 0, 64'h1111_2222_3333_4444);
        rst = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if ({busy, done, err, bus.mm_en_o, bus.mm_valid_o, bus.mm_valid2_o} !== 6'd0 ||
            bus.buf2_addr_o !== 3'd0 || bus.mm_din3_o !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_p2_rst flags got=%b%b%b%b%b%b a2=%0d d3=%0d exp=all 0", busy, done, err,
                     bus.mm_en_o, bus.mm_valid_o, bus.mm_valid2_o, bus.buf2_addr_o, bus.mm_din3_o);
        end
        if (res !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_p2_rst res got=%h exp=0", res);
        end
        rst = 1'b0;
        run_main("rerun", 0, 62, 64'h0F0E_0D0C_0B0A_0908, 0, 0, 64'd0);
    endtask

    task automatic test_short_cfg;
        slot_t      cur, prv;
        logic [4:0] e_a1;
        logic [2:0] e_ctl, e_st;
        logic [7:0] e_d1;
        int         done_at;
        done_at = N2 * K2 + (N2 - 1) * G2 + G2 + L + 2 + TO2 + 1;  // 18
        @(negedge clk);
        start2 = 1'b1;
        for (int t = 1; t <= done_at + 1; t++) begin
            @(negedge clk);
            start2 = 1'b0;
            cur   = slot_at(t, K2, N2, G2, L);
            prv   = slot_at(t - 1, K2, N2, G2, L);
            e_a1  = cur.p1 ? 5'(cur.a1) : 5'd0;
            e_ctl = {prv.p1 | prv.p2, prv.last, prv.fin | prv.gap2 | prv.p2};
            e_d1  = prv.p1 ? mem_x[prv.a1] : 8'd0;
            e_st  = {t <= done_at, t == done_at, t >= done_at};
            n_checks += 4;
            if (bus2.buf1_addr_o !== e_a1) begin
                n_fail++;
                $display("FAIL short t=%0d buf1_addr got=%0d exp=%0d", t, bus2.buf1_addr_o, e_a1);
            end
            if ({bus2.mm_en_o, bus2.mm_valid_o, bus2.mm_valid2_o} !== e_ctl) begin
                n_fail++;
                $display("FAIL short t=%0d en/valid/valid2 got=%b%b%b exp=%b", t,
                         bus2.mm_en_o, bus2.mm_valid_o, bus2.mm_valid2_o, e_ctl);
            end
            if (bus2.mm_din1_o !== e_d1) begin
                n_fail++;
                $display("FAIL short t=%0d din1 got=%0d exp=%0d", t, bus2.mm_din1_o, e_d1);
            end
            if ({busy2, done2, err2} !== e_st) begin
                n_fail++;
                $display("FAIL short t=%0d busy/done/err got=%b%b%b exp=%b", t, busy2, done2, err2, e_st);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_x[i] = (i % 4 == 1) ? 8'd2 : (i % 4 == 2) ? 8'd3 : 8'd1;
            mem_w[i] = {32'hC0DE_0000 + 32'(i), 32'(i * 3 + 7)};
        end
        bus.mm_vld_i     = 1'b0;
        bus.mm_result_i  = 64'd0;
        bus2.mm_vld_i    = 1'b0;
        bus2.mm_result_i = 64'd0;

        test_reset();
        test_phase_capture();
        test_timeout();
        test_timeout_race();
        test_start_ignored();
        test_reset_mid_p2();
        test_short_cfg();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
